sprite_ram_bank: RTL and testbench

- Multi-slot sprite bitmap RAM for the video overlay path: NUM_SLOTS independent sprite images of 2**ADDR_WIDTH pixels each, held in one memory.
- Slot-major addressing: physical address = {slot, addr}.
- Provides:
  - a registered two-stage read pipeline with a chroma-key transparency flag;
  - an external pixel write port;
  - a hardware fill engine that floods one slot with a constant colour, for clearing or recolouring a cursor or sprite without CPU loops.

---
 rtl/sprite_ram_bank_if.sv | 30 +++
 rtl/sprite_ram_bank.sv | 63 ++++++
 tb/tb_sprite_ram_bank.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sprite_ram_bank_if.sv
// sprite_ram_bank_if: bus bundle for the sprite RAM bank (write port, read port, fill engine)
//   master drives write/read/fill requests; slave returns read data, transparency and fill status
interface sprite_ram_bank_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 10,
  parameter int SLOT_BITS  = 2
);
  logic                  we;
  logic [SLOT_BITS-1:0]  slot_w;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [DATA_WIDTH-1:0] din;
  logic [SLOT_BITS-1:0]  slot_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] dout;
  logic                  transparent;
  logic                  fill_start;
  logic [SLOT_BITS-1:0]  fill_slot;
  logic [DATA_WIDTH-1:0] fill_color;
  logic                  fill_busy;
  logic                  fill_done;
  logic                  wr_reject;
  modport master (
    output we, slot_w, addr_w, din, slot_r, addr_r, fill_start, fill_slot, fill_color,
    input  dout, transparent, fill_busy, fill_done, wr_reject
  );
  modport slave (
    input  we, slot_w, addr_w, din, slot_r, addr_r, fill_start, fill_slot, fill_color,
    output dout, transparent, fill_busy, fill_done, wr_reject
  );
endinterface

// File: rtl/sprite_ram_bank.sv
// sprite_ram_bank: multi-slot sprite RAM with 2-stage chroma-key read, external write and slot fill engine
module sprite_ram_bank #(
  parameter int                    DATA_WIDTH = 12,
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    NUM_SLOTS  = 4,
  parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = 12'hF0F,
  parameter string                 INIT_FILE  = "sprites.txt"
) (
  input logic               clk,
  input logic               reset,
  sprite_ram_bank_if.slave  bus
);
  localparam int SLOT_BITS = $clog2(NUM_SLOTS);
  localparam int PW = SLOT_BITS + ADDR_WIDTH;
  localparam int DEPTH = NUM_SLOTS * (2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [SLOT_BITS-1:0]  fslot_q;
  logic [DATA_WIDTH-1:0] fcolor_q, rd_q, dout_q, wdata;
  logic [PW-1:0]         waddr;
  logic                  transp_q, done_q, rej_q, busy, last, wen;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      rej_q    <= 1'b0;
      dout_q   <= '0;
      transp_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= busy && !last ? cnt_q + 1'b1 : '0;
      done_q   <= busy && last;
      rej_q    <= busy && bus.we;
      dout_q   <= rd_q;
      transp_q <= rd_q == KEY_COLOR;
      if (!busy && bus.fill_start) begin
        fslot_q  <= bus.fill_slot;
        fcolor_q <= bus.fill_color;
      end
    end
  end
  always_comb state_d = state_q == IDLE ? (bus.fill_start ? FILL : IDLE) : (last ? IDLE : FILL);
  always_comb begin
    busy  = state_q == FILL;
    last  = cnt_q == LAST;
    wen   = !reset && (busy || bus.we);
    waddr = busy ? {fslot_q, cnt_q} : {bus.slot_w, bus.addr_w};
    wdata = busy ? fcolor_q : bus.din;
  end
  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    rd_q <= mem[{bus.slot_r, bus.addr_r}];
  end
  assign bus.dout        = dout_q;
  assign bus.transparent = transp_q;
  assign bus.fill_busy   = busy;
  assign bus.fill_done   = done_q;
  assign bus.wr_reject   = rej_q;
endmodule

// File: tb/tb_sprite_ram_bank.sv
// tb_sprite_ram_bank: randomized scoreboard bench for sprite_ram_bank against a pixel-array model
module tb_sprite_ram_bank;
  localparam int DW = 12, AW = 10, NS = 4, SB = 2, D = NS << AW, NPIX = 1 << AW;
  localparam logic [DW-1:0] KEY = 12'hF0F;
  typedef struct {bit k; logic [DW-1:0] d; bit t;} exp_t;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  sprite_ram_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLOT_BITS(SB)) bus ();
  sprite_ram_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLOTS(NS), .KEY_COLOR(KEY), .INIT_FILE(""))
    dut (.clk(clk), .reset(reset), .bus(bus));
  logic [DW-1:0] mm [D];
  bit kn [D];
  exp_t q[$];
  bit f_on, e_busy, e_done, e_rej, started, busy_now;
  logic [SB-1:0] f_slot;
  logic [DW-1:0] f_col;
  int f_idx, ra, wa, checks, errors;
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endfunction
  // Reference model: pixel array updated at each rising edge; reads see the pre-edge contents.
  initial forever begin
    @(posedge clk);
    ra = int'({bus.slot_r, bus.addr_r});
    if (reset) begin
      started = 1;
      q.delete();
      q.push_back('{1'b1, '0, 1'b0});
      q.push_back('{kn[ra], mm[ra], mm[ra] == KEY});
      f_on = 0; e_busy = 0; e_done = 0; e_rej = 0;
    end else begin
      q.push_back('{kn[ra], mm[ra], mm[ra] == KEY});
      busy_now = f_on;
      e_rej = busy_now && bus.we;
      e_done = 0;
      if (!busy_now && bus.we) begin
        wa = int'({bus.slot_w, bus.addr_w});
        mm[wa] = bus.din;
        kn[wa] = 1;
      end
      if (busy_now) begin
        wa = int'(f_slot) * NPIX + f_idx;
        mm[wa] = f_col;
        kn[wa] = 1;
        f_idx++;
        if (f_idx == NPIX) begin
          f_on = 0;
          e_done = 1;
        end
      end else if (bus.fill_start) begin
        f_on = 1; f_slot = bus.fill_slot; f_col = bus.fill_color; f_idx = 0;
      end
      e_busy = f_on;
    end
  end
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (started) begin
      if (q.size() > 1) begin
        e = q.pop_front();
        if (e.k) begin
          chk("dout", bus.dout, e.d);
          chk("transparent", bus.transparent, e.t);
        end
      end
      chk("fill_busy", bus.fill_busy, e_busy);
      chk("fill_done", bus.fill_done, e_done);
      chk("wr_reject", bus.wr_reject, e_rej);
    end
  end
  function automatic logic [AW-1:0] pick();
    return $urandom_range(0, 1) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(NPIX - 16, NPIX - 1));
  endfunction
  task automatic tick();
    @(negedge clk);
    bus.we = 0;
    bus.fill_start = 0;
  endtask
  task automatic rnd_read();
    bus.slot_r = SB'($urandom);
    bus.addr_r = pick();
  endtask
  task automatic sweep(int lo, int hi);
    for (int a = lo; a < hi; a++) begin
      {bus.slot_r, bus.addr_r} = (SB + AW)'(a);
      tick();
    end
  endtask
  task automatic start_fill(logic [SB-1:0] s, logic [DW-1:0] c);
    bus.fill_start = 1; bus.fill_slot = s; bus.fill_color = c;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!bus.fill_done && n < 2000) begin
      rnd_read();
      tick();
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL fill_done_timeout got 0 want 1");
    end
  endtask
  initial begin
    bus.we = 0; bus.slot_w = 0; bus.addr_w = 0; bus.din = 0;
    bus.slot_r = 0; bus.addr_r = 0;
    bus.fill_start = 0; bus.fill_slot = 0; bus.fill_color = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    for (int a = 0; a < D; a++) begin
      bus.we = 1;
      {bus.slot_w, bus.addr_w} = (SB + AW)'(a);
      bus.din = DW'($urandom);
      rnd_read();
      tick();
    end
    repeat (400) begin
      bus.we = 1'($urandom);
      bus.slot_w = SB'($urandom);
      bus.addr_w = pick();
      bus.din = $urandom_range(0, 3) == 0 ? KEY : DW'($urandom);
      rnd_read();
      tick();
    end
    bus.we = 1; bus.slot_w = 1; bus.addr_w = '1; bus.din = KEY;
    bus.slot_r = 1; bus.addr_r = '1;
    tick();
    repeat (4) tick();
    start_fill(3, 12'hABC);
    tick();
    for (int i = 0; i < 1100; i++) begin
      rnd_read();
      if (i == 50) begin
        bus.we = 1; bus.slot_w = 0; bus.addr_w = 7; bus.din = DW'($urandom);
      end
      if (i == 300) start_fill(3, 12'hDEF);
      tick();
    end
    sweep(0, D);
    bus.we = 1; bus.slot_w = 3; bus.addr_w = 0; bus.din = 12'h123;
    start_fill(3, 12'h456);
    tick();
    wait_done();
    bus.slot_r = 3; bus.addr_r = 0;
    repeat (4) tick();
    bus.we = 1; bus.slot_w = 1; bus.addr_w = 0; bus.din = 12'h123;
    start_fill(3, 12'h456);
    tick();
    wait_done();
    start_fill(2, 12'h777);
    tick();
    wait_done();
    bus.slot_r = 1; bus.addr_r = 0;
    repeat (4) tick();
    start_fill(0, 12'h5A5);
    tick();
    repeat (100) begin
      rnd_read();
      tick();
    end
    reset = 1;
    tick();
    reset = 0;
    sweep(0, NPIX);
    sweep(2 * NPIX, 3 * NPIX);
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
